// File: rtl/ring_pkg.sv
// ============================================================================
//  Module      : ring_pkg
//  Description : Shared types and packet field layout for the ring router.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ring_pkg;

   localparam int PACKET_SIZE_DEF = 49;
   localparam int VALID_BIT       = PACKET_SIZE_DEF - 1;

   // Lower packet fields: destination, source, then a 32-bit timestamp.
   localparam int DST_OFS = 0;
   localparam int SRC_OFS = 8;
   localparam int TS_OFS  = 16;

   localparam int STARVE_CNT_W = 8;

   typedef enum logic [0:0] {
      NORMAL  = 1'b0,
      STARVED = 1'b1
   } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/ring_arb_stats.sv
// ============================================================================
//  Module      : ring_arb_stats
//  Description : Grant and stall statistics counters for ring_link_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ring_arb_stats (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        transit_pop,
   input  logic        inject_pop,
   input  logic        stall,
   output logic [31:0] grant_transit_cnt,
   output logic [31:0] grant_inject_cnt,
   output logic [31:0] stall_cnt
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_transit_cnt <= '0;
         grant_inject_cnt  <= '0;
         stall_cnt         <= '0;
      end else begin
         if (transit_pop) grant_transit_cnt <= grant_transit_cnt + 32'd1;
         if (inject_pop)  grant_inject_cnt  <= grant_inject_cnt + 32'd1;
         if (stall)       stall_cnt         <= stall_cnt + 32'd1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/ring_link_arbiter.sv
// ============================================================================
//  Module      : ring_link_arbiter
//  Description : Transit-priority output-link arbiter with injection
//                starvation guard. Optional statistics via RING_ARB_STATS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ring_link_arbiter
   import ring_pkg::*;
#(
   parameter int PACKET_SIZE  = PACKET_SIZE_DEF,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [PACKET_SIZE-1:0] transit_pkt,
   input  logic                   transit_valid,
   output logic                   transit_pop,
   input  logic [PACKET_SIZE-1:0] inject_pkt,
   input  logic                   inject_valid,
   output logic                   inject_pop,
   input  logic                   backpressure_rd,
   output logic [PACKET_SIZE-1:0] link_out
`ifdef RING_ARB_STATS_EN
   ,
   output logic [31:0]            grant_transit_cnt,
   output logic [31:0]            grant_inject_cnt,
   output logic [31:0]            stall_cnt
`endif
);

   localparam logic [STARVE_CNT_W-1:0] C_LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

   arb_state_t              r_state;
   logic [STARVE_CNT_W-1:0] r_starve_cnt;

   arb_state_t              w_state_nxt;
   logic [STARVE_CNT_W-1:0] w_cnt_nxt;
   logic                    w_grant_t;
   logic                    w_grant_i;

   always_comb begin
      w_grant_t   = 1'b0;
      w_grant_i   = 1'b0;
      w_state_nxt = r_state;
      w_cnt_nxt   = r_starve_cnt;
      if (!backpressure_rd) begin
         if (r_state == STARVED && inject_valid) begin
            w_grant_i   = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = NORMAL;
         end else begin
            // NORMAL rules; a STARVED state with an empty queue also lands here.
            w_state_nxt = NORMAL;
            w_cnt_nxt   = '0;
            if (transit_valid) begin
               w_grant_t = 1'b1;
               if (r_state == NORMAL && inject_valid) begin
                  w_cnt_nxt = (r_starve_cnt >= C_LIMIT) ? C_LIMIT
                                                        : r_starve_cnt + 1'b1;
                  if (w_cnt_nxt == C_LIMIT) w_state_nxt = STARVED;
               end
            end else if (inject_valid) begin
               w_grant_i = 1'b1;
            end
         end
      end
   end

   assign transit_pop = w_grant_t & rst_n;
   assign inject_pop  = w_grant_i & rst_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= NORMAL;
         r_starve_cnt <= '0;
         link_out     <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_starve_cnt <= w_cnt_nxt;
         if (w_grant_t)
            link_out <= {1'b1, transit_pkt[PACKET_SIZE-2:0]};
         else if (w_grant_i)
            link_out <= {1'b1, inject_pkt[PACKET_SIZE-2:0]};
         else
            link_out <= '0;
      end
   end

`ifdef RING_ARB_STATS_EN
   logic w_stall;
   assign w_stall = backpressure_rd & (transit_valid | inject_valid);

   ring_arb_stats u_stats (
      .clk               (clk),
      .rst_n             (rst_n),
      .transit_pop       (transit_pop),
      .inject_pop        (inject_pop),
      .stall             (w_stall),
      .grant_transit_cnt (grant_transit_cnt),
      .grant_inject_cnt  (grant_inject_cnt),
      .stall_cnt         (stall_cnt)
   );
`endif

endmodule

`default_nettype wire

// File: tb/tb_ring_link_arbiter.sv
// ============================================================================
//  Module      : tb_ring_link_arbiter
//  Description : Directed self-checking bench for ring_link_arbiter
//                (statistics checks active when RING_ARB_STATS_EN is defined).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ring_link_arbiter;

   localparam int PACKET_SIZE = 49;

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic [PACKET_SIZE-1:0] transit_pkt;
   logic                   transit_valid;
   logic                   transit_pop;
   logic [PACKET_SIZE-1:0] inject_pkt;
   logic                   inject_valid;
   logic                   inject_pop;
   logic                   backpressure_rd;
   logic [PACKET_SIZE-1:0] link_out;
`ifdef RING_ARB_STATS_EN
   logic [31:0]            grant_transit_cnt;
   logic [31:0]            grant_inject_cnt;
   logic [31:0]            stall_cnt;
`endif

   int checks = 0;
   int errors = 0;
   int seq    = 0;

   ring_link_arbiter #(
      .PACKET_SIZE  (PACKET_SIZE),
      .STARVE_LIMIT (4)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .transit_pkt       (transit_pkt),
      .transit_valid     (transit_valid),
      .transit_pop       (transit_pop),
      .inject_pkt        (inject_pkt),
      .inject_valid      (inject_valid),
      .inject_pop        (inject_pop),
      .backpressure_rd   (backpressure_rd),
      .link_out          (link_out)
`ifdef RING_ARB_STATS_EN
      ,
      .grant_transit_cnt (grant_transit_cnt),
      .grant_inject_cnt  (grant_inject_cnt),
      .stall_cnt         (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One arbitration cycle, entered and left just after a falling edge.
   // exp_g: "T" transit grant, "I" inject grant, "N" no grant.
   task automatic step(input logic tv, input logic iv, input logic bp,
                       input byte exp_g, input string tag);
      logic [PACKET_SIZE-1:0] exp_link;
      seq++;
      transit_pkt     = {seq[0], 48'hA5A5_0000_0000 | 48'(seq)};
      inject_pkt      = {seq[1], 48'h5A5A_0000_0000 | 48'(seq)};
      transit_valid   = tv;
      inject_valid    = iv;
      backpressure_rd = bp;
      #1;
      check({tag, "/transit_pop"}, 64'(transit_pop), 64'(exp_g == "T"));
      check({tag, "/inject_pop"},  64'(inject_pop),  64'(exp_g == "I"));
      if (exp_g == "T")      exp_link = {1'b1, transit_pkt[PACKET_SIZE-2:0]};
      else if (exp_g == "I") exp_link = {1'b1, inject_pkt[PACKET_SIZE-2:0]};
      else                   exp_link = '0;
      @(posedge clk);
      #1;
      check({tag, "/link_out"}, 64'(link_out), 64'(exp_link));
      @(negedge clk);
   endtask

   initial begin
      rst_n           = 1'b0;
      transit_pkt     = {1'b0, 48'h1111_2222_3333};
      inject_pkt      = {1'b0, 48'h4444_5555_6666};
      transit_valid   = 1'b1;
      inject_valid    = 1'b1;
      backpressure_rd = 1'b0;

      // Reset with both queues valid
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst/link_out",    64'(link_out),    64'd0);
      check("rst/transit_pop", 64'(transit_pop), 64'd0);
      check("rst/inject_pop",  64'(inject_pop),  64'd0);
      rst_n = 1'b1;
      step(1, 1, 0, "T", "first");

      // Injection only, five back-to-back packets
      repeat (5) step(0, 1, 0, "I", "inj_only");

      // Both valid: T,T,T,T,I repeating
      repeat (2) begin
         repeat (4) step(1, 1, 0, "T", "both_t");
         step(1, 1, 0, "I", "both_i");
      end

      // Backpressure while STARVED
      repeat (4) step(1, 1, 0, "T", "pre_bp");
      repeat (3) step(1, 1, 1, "N", "bp");
      step(1, 1, 0, "I", "post_bp");
      step(1, 0, 0, "T", "post_bp_t");

      // Inject drops after two denials: counter restarts
      repeat (2) step(1, 1, 0, "T", "deny2");
      step(1, 0, 0, "T", "inj_drop");
      repeat (4) step(1, 1, 0, "T", "restart_t");
      step(1, 1, 0, "I", "restart_i");

      // STARVED with an empty injection queue falls back to NORMAL
      repeat (4) step(1, 1, 0, "T", "pre_flush");
      step(1, 0, 0, "T", "flush");
      repeat (4) step(1, 1, 0, "T", "after_flush_t");
      step(1, 1, 0, "I", "after_flush_i");

      step(0, 0, 0, "N", "idle");

      // Asynchronous reset mid-operation
      step(1, 1, 0, "T", "pre_rst");
      check("pre_rst/valid", 64'(link_out[PACKET_SIZE-1]), 64'd1);
      rst_n = 1'b0;
      #1;
      check("async_rst/link_out",    64'(link_out),    64'd0);
      check("async_rst/transit_pop", 64'(transit_pop), 64'd0);
      check("async_rst/inject_pop",  64'(inject_pop),  64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Ten cycles both valid, then two stalled cycles
      repeat (2) begin
         repeat (4) step(1, 1, 0, "T", "stats_t");
         step(1, 1, 0, "I", "stats_i");
      end
      repeat (2) step(1, 1, 1, "N", "stats_bp");
`ifdef RING_ARB_STATS_EN
      check("stats/grant_transit_cnt", 64'(grant_transit_cnt), 64'd8);
      check("stats/grant_inject_cnt",  64'(grant_inject_cnt),  64'd2);
      check("stats/stall_cnt",         64'(stall_cnt),         64'd2);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
